// File: rtl/mission_pkg.sv
// Shared types and Open Interface constants for the figure-8 mission controller.
// Packet contents are generated here so the FSM only sequences byte indices.
package mission_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INIT_TX  = 3'd1,
    S_READY    = 3'd2,
    S_LEGA_TX  = 3'd3,
    S_LEGA_RUN = 3'd4,
    S_LEGB_TX  = 3'd5,
    S_LEGB_RUN = 3'd6,
    S_STOP_TX  = 3'd7
  } state_t;

  localparam logic [7:0]  OP_START        = 8'h80;
  localparam logic [7:0]  OP_FULL         = 8'h84;
  localparam logic [7:0]  OP_DRIVE        = 8'h89;
  localparam logic [15:0] RADIUS_STRAIGHT = 16'h8000;

  function automatic logic [2:0] pkt_len(input state_t st);
    return (st == S_INIT_TX) ? 3'd2 : 3'd5;
  endfunction

  // Byte idx of the packet sent in state st; leg B mirrors the radius, stop zeroes speed.
  function automatic logic [7:0] pkt_byte(input state_t st, input logic [2:0] idx,
                                          input logic [15:0] vel, input logic [15:0] rad);
    logic [15:0] v;
    logic [15:0] r;
    logic [7:0]  b;
    v = vel;
    r = rad;
    case (st)
      S_LEGB_TX: r = ~rad + 16'd1;
      S_STOP_TX: begin
        v = '0;
        r = RADIUS_STRAIGHT;
      end
      default: ;
    endcase
    case (idx)
      3'd0:    b = OP_DRIVE;
      3'd1:    b = v[15:8];
      3'd2:    b = v[7:0];
      3'd3:    b = r[15:8];
      default: b = r[7:0];
    endcase
    if (st == S_INIT_TX) b = (idx == 3'd0) ? OP_START : OP_FULL;
    return b;
  endfunction

endpackage

// File: rtl/mission_control_if.sv
// Byte-stream handshake between the mission sequencer and the UART transmitter.
interface mission_control_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;

  modport master (output data, output valid, input  ready);
  modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first. Ready rises on the last stop-bit cycle so a
// waiting byte starts immediately after it, giving back-to-back frames.
module uart_tx #(
  parameter int BIT_CYC = 1736
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(BIT_CYC + 1);

  logic          busy;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] cyc_cnt;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end = (cyc_cnt == CW'(BIT_CYC - 1));
  assign ready   = !busy || (bit_end && bit_cnt == 4'd9);

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy    <= 1'b0;
      bit_cnt <= '0;
      cyc_cnt <= '0;
      shreg   <= '0;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      busy    <= 1'b1;
      tx      <= 1'b0;
      shreg   <= data;
      bit_cnt <= '0;
      cyc_cnt <= '0;
    end else if (busy) begin
      if (bit_end) begin
        cyc_cnt <= '0;
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx   <= 1'b1;
        end else if (bit_cnt == 4'd8) begin
          tx <= 1'b1;
        end else begin
          tx    <= shreg[0];
          shreg <= {1'b0, shreg[7:1]};
        end
      end else begin
        cyc_cnt <= cyc_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/mission_control.sv
// Figure-8 mission controller: conditions buttons, sequences the drive legs and
// streams Open Interface packets to the robot over the UART.
module mission_control
  import mission_pkg::*;
#(
  parameter int                 CLK_HZ          = 100_000_000,
  parameter int                 BAUD            = 57600,
  parameter int                 BIT_CYC         = CLK_HZ / BAUD,
  parameter logic signed [15:0] VELOCITY        = 16'sd200,
  parameter logic signed [15:0] RADIUS          = 16'sd500,
  parameter logic [31:0]        LEG_CYCLES      = 32'd1_570_796_327,
  parameter int                 LOOPS           = 1,
  parameter int                 DEBOUNCE_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] sw,
  input  logic       btnu,
  input  logic       btns,
  input  logic       btnd,
  input  logic       RxD,
  output logic       TxD,
  output logic [7:0] Led
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [2:0] btn_raw;
  logic [2:0] btn_pulse;
  logic       rxd_meta, rxd_sync;
  logic       unused_sw;

  assign btn_raw   = {btnd, btns, btnu};
  assign unused_sw = ^sw[6:0];

  // Pulse is decoded from flops, so it is clean and lands on the edge stable updates.
  for (genvar i = 0; i < 3; i++) begin : g_btn
    logic            meta, sync, stable;
    logic [DB_W-1:0] cnt;
    logic            settle;

    assign settle       = (sync != stable) && (cnt == DB_W'(DEBOUNCE_CYCLES - 1));
    assign btn_pulse[i] = settle && sync;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta   <= 1'b0;
        sync   <= 1'b0;
        stable <= 1'b0;
        cnt    <= '0;
      end else begin
        meta <= btn_raw[i];
        sync <= meta;
        if (sync == stable) begin
          cnt <= '0;
        end else if (settle) begin
          cnt    <= '0;
          stable <= sync;
        end else begin
          cnt <= cnt + DB_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxd_meta <= 1'b1;
      rxd_sync <= 1'b1;
    end else begin
      rxd_meta <= RxD;
      rxd_sync <= rxd_meta;
    end
  end

  state_t      state, state_next;
  logic [2:0]  byte_idx;
  logic [7:0]  loop_cnt;
  logic [31:0] timer;
  logic        tx_active;
  logic        tx_valid, tx_ready, accept;
  logic        abort, in_tx, in_leg, pkt_done, timer_done, last_loop;
  logic [7:0]  tx_byte;

  mission_control_if tx_bus ();

  assign abort      = btn_pulse[2] || !sw[7];
  assign in_tx      = state inside {S_INIT_TX, S_LEGA_TX, S_LEGB_TX, S_STOP_TX};
  assign in_leg     = state inside {S_LEGA_TX, S_LEGA_RUN, S_LEGB_TX, S_LEGB_RUN};
  assign accept     = tx_valid && tx_ready;
  assign pkt_done   = in_tx && (byte_idx == pkt_len(state)) && tx_active && tx_ready;
  assign timer_done = (timer == LEG_CYCLES - 32'd1);
  assign last_loop  = ({24'd0, loop_cnt} + 32'd1) >= 32'(LOOPS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    tx_valid   = 1'b0;
    tx_byte    = pkt_byte(state, byte_idx, VELOCITY, RADIUS);
    if (in_tx && byte_idx < pkt_len(state) && !(in_leg && abort)) tx_valid = 1'b1;
    case (state)
      S_IDLE:     if (btn_pulse[0]) state_next = S_INIT_TX;
      S_INIT_TX:  if (pkt_done) state_next = S_READY;
      S_READY: begin
        if (btn_pulse[0])                state_next = S_INIT_TX;
        else if (btn_pulse[1] && sw[7])  state_next = S_LEGA_TX;
      end
      S_LEGA_TX:  if (abort) state_next = S_STOP_TX; else if (pkt_done)   state_next = S_LEGA_RUN;
      S_LEGA_RUN: if (abort) state_next = S_STOP_TX; else if (timer_done) state_next = S_LEGB_TX;
      S_LEGB_TX:  if (abort) state_next = S_STOP_TX; else if (pkt_done)   state_next = S_LEGB_RUN;
      S_LEGB_RUN: begin
        if (abort)           state_next = S_STOP_TX;
        else if (timer_done) state_next = last_loop ? S_STOP_TX : S_LEGA_TX;
      end
      S_STOP_TX:  if (pkt_done) state_next = S_READY;
      default:    state_next = S_IDLE;
    endcase
  end

  // tx_active drops exactly when the final stop bit ends (ready high, nothing accepted).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_idx  <= '0;
      loop_cnt  <= '0;
      timer     <= '0;
      tx_active <= 1'b0;
    end else begin
      if (accept)        tx_active <= 1'b1;
      else if (tx_ready) tx_active <= 1'b0;
      if (state_next != state) begin
        byte_idx <= '0;
        timer    <= '0;
      end else begin
        if (accept) byte_idx <= byte_idx + 3'd1;
        if (state == S_LEGA_RUN || state == S_LEGB_RUN) timer <= timer + 32'd1;
      end
      if (state == S_READY && state_next == S_LEGA_TX)
        loop_cnt <= '0;
      else if (state == S_LEGB_RUN && timer_done && !abort)
        loop_cnt <= loop_cnt + 8'd1;
    end
  end

  assign tx_bus.data  = tx_byte;
  assign tx_bus.valid = tx_valid;
  assign tx_ready     = tx_bus.ready;

  uart_tx #(.BIT_CYC(BIT_CYC)) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_bus.data),
    .valid (tx_bus.valid),
    .ready (tx_bus.ready),
    .tx    (TxD)
  );

  assign Led = {rxd_sync, tx_active, sw[7], state, loop_cnt[1:0]};

endmodule

// File: tb/tb_mission_control.sv
// Directed bench for mission_control: decodes TxD into bytes with frame timestamps
// and compares packets, spacing, latency and state LEDs against hand-derived values.
module tb_mission_control;

  localparam int BIT_CYC = 8;
  localparam int FRAME   = 10 * BIT_CYC;
  localparam logic [2:0] ST_IDLE = 3'd0, ST_INIT = 3'd1, ST_READY = 3'd2,
                         ST_LEGA_RUN = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] sw = 8'h00;
  logic       btnu = 1'b0, btns = 1'b0, btnd = 1'b0, rxd = 1'b1;
  logic       txd;
  logic [7:0] led;

  int n_checks = 0, n_errors = 0, frame_err = 0, cyc = 0;
  logic [7:0] rx_q[$];
  int         rx_t[$];
  int         pkt_first_t, pkt_last_t;

  mission_control #(
    .BIT_CYC    (BIT_CYC),
    .LEG_CYCLES (32'd2000),
    .LOOPS      (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (sw),
    .btnu  (btnu),
    .btns  (btns),
    .btnd  (btnd),
    .RxD   (rxd),
    .TxD   (txd),
    .Led   (led)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete (checks %0d)", n_checks);
    $fatal(1, "watchdog expired");
  end

  // UART receiver model: samples mid-bit, timestamps each frame start.
  always begin
    logic [7:0] b;
    int t;
    @(negedge txd);
    #1 t = cyc;
    repeat (BIT_CYC / 2) @(posedge clk);
    #1 if (txd !== 1'b0) frame_err++;
    for (int k = 0; k < 8; k++) begin
      repeat (BIT_CYC) @(posedge clk);
      #1 b[k] = txd;
    end
    repeat (BIT_CYC) @(posedge clk);
    #1 if (txd !== 1'b1) frame_err++;
    rx_q.push_back(b);
    rx_t.push_back(t);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input string tag, input logic [2:0] exp, input int budget);
    int w = 0;
    while (led[4:2] !== exp && w < budget) begin
      tick(1);
      w++;
    end
    check(tag, 32'(led[4:2]), 32'(exp));
  endtask

  // exp holds the n expected bytes MSB-first; frames within one call must be back-to-back.
  task automatic expect_bytes(input string tag, input logic [47:0] exp, input int n,
                              input int budget);
    int w = 0;
    int t, prev_t;
    logic [7:0] got, want;
    prev_t = 0;
    while (rx_q.size() < n && w < budget) begin
      tick(1);
      w++;
    end
    for (int k = 0; k < n; k++) begin
      want = exp[8*(n-1-k) +: 8];
      if (rx_q.size() > 0) begin
        got = rx_q.pop_front();
        t   = rx_t.pop_front();
      end else begin
        got = 'x;
        t   = -1;
      end
      check($sformatf("%s_b%0d", tag, k), 32'(got), 32'(want));
      if (k == 0) pkt_first_t = t;
      else        check($sformatf("%s_gap%0d", tag, k), 32'(t - prev_t), 32'(FRAME));
      prev_t = t;
    end
    pkt_last_t = prev_t;
  endtask

  initial begin
    int w, last_t, gap, t_clear;

    // Reset state
    tick(3);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_state", 32'(led[4:2]), 32'(ST_IDLE));
    check("rst_busy", 32'(led[6]), 32'd0);
    check("rst_loop", 32'(led[1:0]), 32'd0);
    check("rst_sw_led", 32'(led[5]), 32'd0);
    rst_n = 1'b1;
    tick(5);
    check("rxd_led", 32'(led[7]), 32'd1);

    // No activity without buttons
    tick(10000);
    check("idle_quiet", 32'(rx_q.size()), 32'd0);
    check("idle_state", 32'(led[4:2]), 32'(ST_IDLE));

    // Init: 2 sync + 16 debounce, start bit on the following cycle
    btnu = 1'b1;
    w = 0;
    while (txd !== 1'b0 && w < 100) begin
      tick(1);
      w++;
    end
    check("init_latency", 32'(w), 32'd19);
    check("init_busy", 32'(led[6]), 32'd1);
    check("init_state", 32'(led[4:2]), 32'(ST_INIT));
    tick(100);
    btnu = 1'b0;
    wait_state("init_ready", ST_READY, 400);
    expect_bytes("init", 48'h8084, 2, 10);
    tick(200);
    check("init_only2", 32'(rx_q.size()), 32'd0);

    // Start ignored while mission enable is low
    btns = 1'b1;
    tick(40);
    btns = 1'b0;
    tick(400);
    check("nogo_quiet", 32'(rx_q.size()), 32'd0);
    check("nogo_state", 32'(led[4:2]), 32'(ST_READY));

    // Full figure-8, start held long
    sw = 8'h80;
    tick(2);
    check("sw_led", 32'(led[5]), 32'd1);
    btns = 1'b1;
    tick(300);
    btns = 1'b0;
    expect_bytes("lega", 48'h89_00C8_01F4, 5, 1000);
    last_t = pkt_last_t;
    wait_state("lega_run", ST_LEGA_RUN, 50);
    expect_bytes("legb", 48'h89_00C8_FE0C, 5, 3000);
    gap = pkt_first_t - last_t;
    check("lega_leg_gap", 32'(gap >= FRAME + 2000 && gap <= FRAME + 2004), 32'd1);
    last_t = pkt_last_t;
    expect_bytes("stop", 48'h89_0000_8000, 5, 3000);
    gap = pkt_first_t - last_t;
    check("legb_leg_gap", 32'(gap >= FRAME + 2000 && gap <= FRAME + 2004), 32'd1);
    wait_state("run_done", ST_READY, 200);
    check("run_loops", 32'(led[1:0]), 32'd1);
    tick(3000);
    check("one_run", 32'(rx_q.size()), 32'd0);
    check("one_run_state", 32'(led[4:2]), 32'(ST_READY));

    // Mission enable dropped during leg A run
    btns = 1'b1;
    tick(40);
    btns = 1'b0;
    expect_bytes("lega2", 48'h89_00C8_01F4, 5, 1000);
    wait_state("lega2_run", ST_LEGA_RUN, 50);
    tick(500);
    sw = 8'h00;
    t_clear = cyc;
    expect_bytes("abort_sw", 48'h89_0000_8000, 5, 1000);
    check("abort_sw_lat", 32'(pkt_first_t - t_clear <= 50 * BIT_CYC), 32'd1);
    wait_state("abort_sw_ready", ST_READY, 200);
    check("abort_sw_loop", 32'(led[1:0]), 32'd0);
    sw = 8'h80;

    // Abort button during the third byte of leg B packet
    btns = 1'b1;
    tick(40);
    btns = 1'b0;
    expect_bytes("lega3", 48'h89_00C8_01F4, 5, 1000);
    expect_bytes("legb3", 48'h8900, 2, 3000);
    tick(40);
    btnd = 1'b1;
    tick(30);
    btnd = 1'b0;
    expect_bytes("abort_btn", 48'hC8_89_00_00_80_00, 6, 1000);
    wait_state("abort_btn_ready", ST_READY, 200);
    tick(500);
    check("abort_btn_quiet", 32'(rx_q.size()), 32'd0);
    check("framing", 32'(frame_err), 32'd0);

    // Reset in the middle of a byte
    btns = 1'b1;
    w = 0;
    while (txd !== 1'b0 && w < 100) begin
      tick(1);
      w++;
    end
    check("rst_mid_start", 32'(txd), 32'd0);
    tick(20);
    #3 rst_n = 1'b0;
    #1 check("rst_mid_txd", 32'(txd), 32'd1);
    check("rst_mid_state", 32'(led[4:2]), 32'(ST_IDLE));
    btns = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(50);
    check("post_rst_state", 32'(led[4:2]), 32'(ST_IDLE));
    check("post_rst_txd", 32'(txd), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
